apb_reg_slave: RTL

APB completer (responder) register block for the RAL test environment: it sits on the far side of the APB bus from the RAL driver and answers its psel/penable/pwrite/paddr/pwdata transfers with prdata. It holds a small register map (control, scratch data, a gated 32-bit event counter, compare, and W1C interrupt status/enable), which gives the RAL model mirrored, read-only, volatile and W1C fields to check. There is no pready/pslverr: every transfer is zero-wait-state.

---
 rtl/apb_reg_slave.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB completer register block with gated event counter and W1C interrupts
module apb_reg_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  irq
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_wr_commit;
    logic                  w_rd_capture;

    logic                  r_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic [31:0]           r_count;
    logic [1:0]            r_intr;
    logic [DATA_WIDTH-1:0] r_cmp;
    logic [1:0]            r_inten;
    logic                  r_irq;
    logic [DATA_WIDTH-1:0] r_prdata;

    logic                  w_hi_nonzero;
    logic [2:0]            w_idx;
    logic                  w_hit;
    logic                  w_we_ctrl;
    logic                  w_we_data;
    logic                  w_we_intr;
    logic                  w_we_cmp;
    logic                  w_we_inten;
    logic                  w_clr;
    logic                  w_wrap_set;
    logic                  w_match_set;
    logic [1:0]            w_w1c_mask;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_addr;

    // Address decode: word index from [4:2], upper bits must be clear for a hit
    assign w_hi_nonzero  = |paddr[ADDR_WIDTH-1:5];
    assign w_idx         = paddr[4:2];
    assign w_hit         = !w_hi_nonzero && (w_idx != 3'd7);
    assign w_unused_addr = ^paddr[1:0];

    // Protocol state register
    always_ff @(posedge pclk) begin
        if (preset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; penable while idle is a protocol error and keeps us idle
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:   w_state_nxt = (psel && !penable) ? S_SETUP : S_IDLE;
            S_SETUP: begin
                if (!psel)        w_state_nxt = S_IDLE;
                else if (penable) w_state_nxt = S_ACCESS;
                else              w_state_nxt = S_SETUP;
            end
            S_ACCESS: w_state_nxt = (psel && !penable) ? S_SETUP : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Transfer strobes: commit writes leaving SETUP, capture reads entering SETUP
    always_comb begin
        w_wr_commit  = (r_state == S_SETUP) && psel && penable && pwrite;
        w_rd_capture = psel && !penable && !pwrite;
    end

    assign w_we_ctrl  = w_wr_commit && w_hit && (w_idx == 3'd0);
    assign w_we_data  = w_wr_commit && w_hit && (w_idx == 3'd1);
    assign w_we_intr  = w_wr_commit && w_hit && (w_idx == 3'd4);
    assign w_we_cmp   = w_wr_commit && w_hit && (w_idx == 3'd5);
    assign w_we_inten = w_wr_commit && w_hit && (w_idx == 3'd6);

    // Counter events use the pre-edge EN and count; CLR suppresses the increment and any wrap
    assign w_clr       = w_we_ctrl && pwdata[1];
    assign w_wrap_set  = r_en && !w_clr && (r_count == 32'hFFFF_FFFF);
    assign w_match_set = r_en && (r_count == r_cmp[31:0]);
    assign w_w1c_mask  = w_we_intr ? pwdata[1:0] : 2'b00;

    // Software-writable configuration registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_en    <= 1'b0;
            r_data  <= '0;
            r_cmp   <= '0;
            r_inten <= 2'b00;
        end else begin
            if (w_we_ctrl)  r_en    <= pwdata[0];
            if (w_we_data)  r_data  <= pwdata;
            if (w_we_cmp)   r_cmp   <= pwdata;
            if (w_we_inten) r_inten <= pwdata[1:0];
        end
    end

    // Event counter: clear beats increment
    always_ff @(posedge pclk) begin
        if (preset)     r_count <= '0;
        else if (w_clr) r_count <= '0;
        else if (r_en)  r_count <= r_count + 32'd1;
    end

    // Interrupt status: hardware set wins over a same-cycle W1C; irq follows one edge later
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_intr <= 2'b00;
            r_irq  <= 1'b0;
        end else begin
            r_intr <= (r_intr & ~w_w1c_mask) | {w_match_set, w_wrap_set};
            r_irq  <= |(r_intr & r_inten);
        end
    end

    // Read data mux over pre-edge register values
    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_idx)
                3'd0:    w_rdata = {{(DATA_WIDTH-1){1'b0}}, r_en};
                3'd1:    w_rdata = r_data;
                3'd2:    w_rdata = {{(DATA_WIDTH-2){1'b0}}, r_irq, r_en};
                3'd3:    w_rdata = r_count;
                3'd4:    w_rdata = {{(DATA_WIDTH-2){1'b0}}, r_intr};
                3'd5:    w_rdata = r_cmp;
                3'd6:    w_rdata = {{(DATA_WIDTH-2){1'b0}}, r_inten};
                default: w_rdata = '0;
            endcase
        end
    end

    // Read data register, held until the next capture
    always_ff @(posedge pclk) begin
        if (preset)            r_prdata <= '0;
        else if (w_rd_capture) r_prdata <= w_rdata;
    end

    assign prdata = r_prdata;
    assign irq    = r_irq;

endmodule
